// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU fetch and LSU load/store traffic.
// One transaction in flight, LSU-priority with IFU anti-starvation, per-txn timeout.
//
// Ports:
//   clk, rst              : clock, async active-high reset
//   ifu_req_* / ifu_resp_*: IFU read-only request handshake and response pulse
//   lsu_req_* / lsu_resp_*: LSU read/write request handshake and response pulse
//   mem_req_* / mem_resp_*: registered request to memory and its response
//   busy                  : a transaction is in progress
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int MASK_WIDTH   = 8,
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [MASK_WIDTH-1:0] lsu_wmask,
  output logic                  lsu_resp_valid,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  lsu_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  starved;
  logic                  grant_lsu;
  logic                  grant_ifu;
  logic                  idle;
  logic                  tmo_hit;
  logic                  resp_lsu;
  logic                  resp_ifu;

  // owner_q: 1 = LSU, 0 = IFU
  assign idle      = (state_q == IDLE);
  assign starved   = ifu_req_valid && (starve_q == SW'(STARVE_LIMIT));
  assign grant_lsu = idle && lsu_req_valid && !starved;
  assign grant_ifu = idle && ifu_req_valid && !grant_lsu;
  // Abort fires on the cycle whose increment lands on TIMEOUT.
  assign tmo_hit   = ((tmo_q + TW'(1)) == TW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          owner_d = 1'b1;
          addr_d  = lsu_addr;
          wen_d   = lsu_wen;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wen ? lsu_wmask : '0;
          tmo_d   = '0;
          state_d = ISSUE;
          if (ifu_req_valid && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);
        end else if (grant_ifu) begin
          owner_d  = 1'b0;
          addr_d   = ifu_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wmask_d  = '0;
          tmo_d    = '0;
          starve_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (mem_resp_valid) begin
          rdata_d = wen_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Readies are gated by rst so every output is 0 while reset is held.
  assign ifu_req_ready  = !rst && grant_ifu;
  assign lsu_req_ready  = !rst && grant_lsu;

  assign resp_lsu       = (state_q == RESP) && owner_q;
  assign resp_ifu       = (state_q == RESP) && !owner_q;

  assign ifu_resp_valid = resp_ifu;
  assign ifu_rdata      = resp_ifu ? rdata_q : '0;
  assign ifu_err        = resp_ifu && err_q;
  assign lsu_resp_valid = resp_lsu;
  assign lsu_rdata      = resp_lsu ? rdata_q : '0;
  assign lsu_err        = resp_lsu && err_q;

  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_addr       = addr_q;
  assign mem_wen        = wen_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign busy           = !idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Memory timing per txn is scripted as (ready delay, response delay).
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int T  = 8;
  localparam int SL = 4;
  localparam int NORESP = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready;
  logic [AW-1:0] ifu_addr;
  logic          ifu_resp_valid, ifu_err;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          lsu_resp_valid, lsu_err;
  logic          mem_req_valid, mem_req_ready, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_resp_valid, busy;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .TIMEOUT(T), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: pending requests held by requesters plus starvation count.
  int            starve;
  bit            ip, lp, lw;
  logic [AW-1:0] ia, la;
  logic [DW-1:0] lwd;
  logic [MW-1:0] lm;
  int            n_lsu_win, n_ifu_win;

  task automatic drive_reqs();
    ifu_req_valid = ip;
    ifu_addr      = ia;
    lsu_req_valid = lp;
    lsu_addr      = la;
    lsu_wen       = lw;
    lsu_wdata     = lwd;
    lsu_wmask     = lm;
  endtask

  // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the
  // cycle after the response pulse.
  task automatic do_txn(input int d1, input int d2);
    bit            lw_win, err;
    int            r, span;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, capt, exp_rd;
    logic [MW-1:0] em;
    bit            ew;
    capt = '0;
    drive_reqs();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'($urandom % 2);
    mem_rdata      = {$urandom, $urandom};
    #3;
    lw_win = lp && !(ip && starve == SL);
    chk("idle_busy", busy, 0);
    chk("lsu_ready", lsu_req_ready, lw_win);
    chk("ifu_ready", ifu_req_ready, ip && !lw_win);
    chk("idle_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
    if (lw_win) begin
      n_lsu_win++;
      ea = la; ew = lw; ewd = lwd; em = lw ? lm : '0;
      if (ip) starve = (starve + 1 > SL) ? SL : starve + 1;
      lp = 1'b0;
    end else begin
      n_ifu_win++;
      ea = ia; ew = 1'b0; ewd = '0; em = '0;
      starve = 0;
      ip = 1'b0;
    end
    span = d1 + d2 + 2;
    r    = (span < T) ? span : T;
    err  = (span >= T);
    @(posedge clk); #1;
    drive_reqs();
    for (int k = 0; k <= r; k++) begin
      mem_rdata     = {$urandom, $urandom};
      mem_req_ready = (k == d1) ? 1'b1 :
                      (k > d1) ? 1'($urandom % 2) : 1'b0;
      if (k == d1 + 1 + d2) begin
        mem_resp_valid = 1'b1;
        capt = mem_rdata;
      end else begin
        mem_resp_valid = (k <= d1 || k == r) ? 1'($urandom % 2) : 1'b0;
      end
      #3;
      chk("busy", busy, 1);
      chk("mreq_v", mem_req_valid, (k <= d1 && k < r));
      chk("readies", {ifu_req_ready, lsu_req_ready}, 0);
      if (k <= d1 && k < r) begin
        chk("maddr", mem_addr, ea);
        chk("mwen", mem_wen, ew);
        chk("mwmask", mem_wmask, em);
        if (ew || !lw_win) chk("mwdata", mem_wdata, ewd);
      end
      exp_rd = (err || ew) ? '0 : capt;
      chk("ifu_rv", ifu_resp_valid, k == r && !lw_win);
      chk("lsu_rv", lsu_resp_valid, k == r && lw_win);
      chk("ifu_rd", ifu_rdata, (k == r && !lw_win) ? exp_rd : '0);
      chk("lsu_rd", lsu_rdata, (k == r && lw_win) ? exp_rd : '0);
      chk("ifu_err", ifu_err, k == r && !lw_win && err);
      chk("lsu_err", lsu_err, k == r && lw_win && err);
      @(posedge clk); #1;
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic new_ifu();
    ip = 1'b1;
    ia = {$urandom, $urandom};
  endtask

  task automatic new_lsu();
    lp  = 1'b1;
    la  = {$urandom, $urandom};
    lw  = 1'($urandom % 2);
    lwd = {$urandom, $urandom};
    lm  = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, {ifu_req_ready, lsu_req_ready}, 0);
    chk({tag, "_rv"}, {ifu_resp_valid, lsu_resp_valid}, 0);
    chk({tag, "_rd"}, ifu_rdata | lsu_rdata, 0);
    chk({tag, "_err"}, {ifu_err, lsu_err}, 0);
    chk({tag, "_mreq"}, {mem_req_valid, mem_wen, busy}, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_mwdata"}, mem_wdata, 0);
    chk({tag, "_mwmask"}, mem_wmask, 0);
  endtask

  initial begin
    ip = 0; lp = 0; lw = 0; ia = '0; la = '0; lwd = '0; lm = '0;
    starve = 0; n_lsu_win = 0; n_ifu_win = 0;
    drive_reqs();
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single IFU read with fixed address
    ip = 1; ia = 64'h8000_0000;
    do_txn(0, 0);

    // Simultaneous requests, LSU store wins at starve 0
    new_ifu();
    lp = 1; la = 64'h8000_1000; lw = 1;
    lwd = 64'hDEAD_BEEF; lm = 8'h0F;
    do_txn(0, 0);

    // Both requesters held continuously
    n_lsu_win = 0; n_ifu_win = 0;
    for (int i = 0; i < 6; i++) begin
      if (!lp) new_lsu();
      if (!ip) new_ifu();
      do_txn(0, 0);
    end

    // Timeout with no response, then a stray response in IDLE
    ip = 0; lp = 0;
    new_ifu();
    do_txn(0, NORESP);
    drive_reqs();
    mem_resp_valid = 1'b1;
    #3;
    chk("stray_rv", {ifu_resp_valid, lsu_resp_valid}, 0);
    chk("stray_busy", busy, 0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;

    // Back-pressure on the memory request
    lp = 1; la = 64'h8000_2000; lw = 1;
    lwd = 64'h0123_4567_89AB_CDEF; lm = 8'hA5;
    do_txn(3, 0);

    // Async reset mid-WAIT
    new_ifu();
    drive_reqs();
    @(posedge clk); #1;
    ifu_req_valid = 0;
    mem_req_ready = 1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    #1 rst = 1'b1;
    #1;
    chk_all_zero("arst");
    @(posedge clk); #1;
    chk("arst_rv", {ifu_resp_valid, lsu_resp_valid}, 0);
    rst = 1'b0;
    ip = 0; lp = 0; starve = 0;
    drive_reqs();
    @(posedge clk); #1;
    chk("arst_rv2", {ifu_resp_valid, lsu_resp_valid}, 0);
    new_ifu();
    do_txn(1, 1);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int d1, d2;
      if (!ip && ($urandom % 2)) new_ifu();
      if (!lp && ($urandom % 2)) new_lsu();
      if (!ip && !lp) new_lsu();
      d1 = $urandom % 4;
      d2 = $urandom % 4;
      if ($urandom % 8 == 0) d2 = NORESP;
      if ($urandom % 10 == 0) d1 = 9;
      do_txn(d1, d2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write). It replaces the core's direct combinational memory hookup once fetch and data accesses become multi-cycle. The block uses valid/ready request handshakes and one-cycle response pulses, with one transaction in flight at a time. Arbitration is LSU-priority with an anti-starvation limit for the IFU, and each transaction has a timeout.

Parameters:
ADDR_WIDTH, 64, address width
DATA_WIDTH, 64, data width
MASK_WIDTH, 8, byte write-mask width (DATA_WIDTH/8)
TIMEOUT, 255, cycles allowed in ISSUE+WAIT before abort with error
STARVE_LIMIT, 4, consecutive LSU grants while IFU is pending before IFU is forced

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_WIDTH  fetch address
ifu_resp_valid  out  1  one-cycle IFU response pulse
ifu_rdata  out  DATA_WIDTH  fetch data
ifu_err  out  1  IFU response is a timeout error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_WIDTH  load/store address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_WIDTH  store data
lsu_wmask  in  MASK_WIDTH  store byte mask
lsu_resp_valid  out  1  one-cycle LSU response pulse
lsu_rdata  out  DATA_WIDTH  load data (0 for stores)
lsu_err  out  1  LSU response is a timeout error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  registered address
mem_wen  out  1  registered write enable (0 for IFU)
mem_wdata  out  DATA_WIDTH  registered store data
mem_wmask  out  MASK_WIDTH  registered mask (0 for loads/IFU)
mem_resp_valid  in  1  memory response
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, starve_cnt=0, timeout_cnt=0, owner=IFU. All outputs are 0, including the mem_* registers. Any in-flight transaction is dropped without a response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant is combinational:
  - LSU wins if lsu_req_valid, unless ifu_req_valid && starve_cnt==STARVE_LIMIT.
  - Otherwise IFU wins if ifu_req_valid.
  - The winner's req_ready is 1 and the loser's is 0.
  - On handshake: latch addr, wen, wdata and wmask (IFU: wen=0, wmask=0, wdata=0), set owner, clear timeout_cnt, go to ISSUE.
  - No request: stay in IDLE.
- req_ready is 0 in every state other than IDLE. Requesters hold their request.
- starve_cnt:
  - On an LSU grant with ifu_req_valid=1: +1, saturating at STARVE_LIMIT.
  - On an LSU grant with ifu_req_valid=0: unchanged.
  - On an IFU grant: cleared to 0.
- ISSUE: mem_req_valid=1 with the latched fields held stable. Go to WAIT on mem_req_ready.
- WAIT: mem_req_valid=0. On mem_resp_valid, capture mem_rdata (captured value forced to 0 for stores) and go to RESP with err=0.
- mem_resp_valid is sampled only in WAIT. A response arriving in the same cycle as ISSUE's handshake is ignored. Stray responses in IDLE, ISSUE or RESP are ignored.
- Timeout:
  - timeout_cnt increments each cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT, go to RESP with err=1 and rdata=0, and drop mem_req_valid.
  - An abort takes precedence over a mem_resp_valid in the same cycle.
- RESP: the owner's resp_valid=1 for exactly one cycle, with rdata and err valid. The other requester's resp outputs are 0. Next state is IDLE. Responses cannot be back-pressured.
- rdata and err outputs are 0 whenever resp_valid=0.
- Latency: accept at cycle N, mem_req_valid at N+1. With mem_req_ready at N+1 and mem_resp_valid at N+2, resp_valid is at N+3 (minimum). Back-to-back throughput is one transaction per 4 cycles.
- Width rules: no arithmetic on data or addresses. timeout_cnt is $clog2(TIMEOUT+1) bits and starve_cnt is $clog2(STARVE_LIMIT+1) bits, both unsigned and non-wrapping.

Test Plan:
- Reset then single IFU read: addr 0x80000000 accepted at cycle 0, memory ready at 1, resp at 2 with rdata 0x00100073 → ifu_resp_valid at cycle 3, ifu_rdata=0x00100073, ifu_err=0, busy 0 at cycle 4.
- Simultaneous requests, starve_cnt 0: LSU store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F → lsu_req_ready=1, ifu_req_ready=0; mem_wen=1, mem_wmask=0x0F; lsu_resp_valid with lsu_rdata=0.
- Starvation: both valid continuously for 6 transactions → grants are LSU×4, then IFU, then LSU; starve_cnt reads 4, then 0.
- Timeout: IFU request, memory holds mem_req_ready=1 but never responds, TIMEOUT=8 → ifu_resp_valid with ifu_err=1 and ifu_rdata=0 exactly 8 cycles after ISSUE entry. A later stray mem_resp_valid in IDLE produces no pulse.
- Back-pressure: mem_req_ready low for 3 cycles → mem_addr, mem_wdata and mem_wmask are stable for all ISSUE cycles; the response arrives 3 cycles later than in the first scenario.
- Async reset asserted mid-WAIT (between clock edges) → all outputs 0 immediately, no resp pulse. After release, a new IFU request is granted normally.
